// File: rtl/ahb_data_mem_slave.sv
// AHB-Lite word-addressed data memory slave with configurable wait states
// and a two-cycle ERROR response for illegal transfers.
module ahb_data_mem_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [2:0] {StIdle, StWait, StDone, StErr1, StErr2} state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] dp_idx_q;
  logic             dp_write_q;
  logic             dp_err_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             addr_err;
  logic [31:0]      offset;
  logic             unused_offset;

  // Only cycles where HREADY can legitimately be high may start a new data phase.
  assign accept = HSEL && HREADY && HTRANS[1] &&
                  (state_q == StIdle || state_q == StDone || state_q == StErr2);

  assign addr_err = (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00) ||
                    (HADDR < BASE_ADDR) || ({1'b0, HADDR} >= END_ADDR);

  assign offset        = HADDR - BASE_ADDR;
  assign unused_offset = ^{offset[31:IDX_W+2], offset[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone, StErr2: begin
        if (accept) begin
          if (addr_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 3'(WAIT_STATES);
          end else begin
            state_d = StDone;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = StDone;
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      dp_idx_q   <= '0;
      dp_write_q <= 1'b0;
      dp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        dp_idx_q   <= offset[IDX_W+1:2];
        dp_write_q <= HWRITE;
        dp_err_q   <= addr_err;
      end
    end
  end

  // Memory is not reset; reset forces StIdle asynchronously so no write can follow it.
  always_ff @(posedge clk) begin
    if (state_q == StDone && dp_write_q && !dp_err_q) begin
      mem[dp_idx_q] <= HWDATA;
    end
  end

  always_comb begin
    HREADYOUT = !(state_q == StWait || state_q == StErr1);
    HRESP     = (state_q == StErr1 || state_q == StErr2);
    HRDATA    = '0;
    if (state_q == StDone && !dp_write_q) HRDATA = mem[dp_idx_q];
  end

endmodule

// File: tb/tb_ahb_data_mem_slave.sv
// Directed self-checking bench: one-wait-state slave for the main sequences,
// a zero-wait-state instance for back-to-back write/read.
module tb_ahb_data_mem_slave;

  logic        clk;
  logic        rst;

  // Bus for the WAIT_STATES=1 instance
  logic        h_sel;
  logic [31:0] h_addr;
  logic [1:0]  h_trans;
  logic        h_write;
  logic [2:0]  h_size;
  logic [31:0] h_wdata;
  logic [31:0] h_rdata;
  logic        h_readyout;
  logic        h_resp;

  // Bus for the WAIT_STATES=0 instance
  logic        z_sel;
  logic [31:0] z_addr;
  logic [1:0]  z_trans;
  logic        z_write;
  logic [2:0]  z_size;
  logic [31:0] z_wdata;
  logic [31:0] z_rdata;
  logic        z_readyout;
  logic        z_resp;

  int n_tests = 0;
  int n_fail  = 0;

  ahb_data_mem_slave #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0000_0000),
    .WAIT_STATES(1)
  ) u_ws1 (
    .clk      (clk),
    .rst      (rst),
    .HSEL     (h_sel),
    .HADDR    (h_addr),
    .HTRANS   (h_trans),
    .HWRITE   (h_write),
    .HSIZE    (h_size),
    .HWDATA   (h_wdata),
    .HREADY   (h_readyout),
    .HRDATA   (h_rdata),
    .HREADYOUT(h_readyout),
    .HRESP    (h_resp)
  );

  ahb_data_mem_slave #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0000_0000),
    .WAIT_STATES(0)
  ) u_ws0 (
    .clk      (clk),
    .rst      (rst),
    .HSEL     (z_sel),
    .HADDR    (z_addr),
    .HTRANS   (z_trans),
    .HWRITE   (z_write),
    .HSIZE    (z_size),
    .HWDATA   (z_wdata),
    .HREADY   (z_readyout),
    .HRDATA   (z_rdata),
    .HREADYOUT(z_readyout),
    .HRESP    (z_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic rdy, input logic resp,
                           input logic [31:0] rdata);
    check({tag, ".ready"}, {31'd0, h_readyout}, {31'd0, rdy});
    check({tag, ".resp"},  {31'd0, h_resp},     {31'd0, resp});
    check({tag, ".rdata"}, h_rdata, rdata);
  endtask

  task automatic bus_idle();
    h_sel   = 1'b0;
    h_trans = 2'b00;
  endtask

  // Called at posedge+1 with the slave idle; returns at posedge+1 with the slave idle.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rdata);
    h_sel   = 1'b1;
    h_trans = 2'b10;
    h_write = wr;
    h_addr  = addr;
    h_size  = size;
    @(posedge clk); #1;
    bus_idle();
    h_wdata = wdata;
    if (!exp_err) begin
      @(negedge clk); check_bus({tag, ".wait"}, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      @(negedge clk); check_bus({tag, ".done"}, 1'b1, 1'b0, exp_rdata);
      @(posedge clk); #1;
    end else begin
      @(negedge clk); check_bus({tag, ".err1"}, 1'b0, 1'b1, 32'h0);
      @(posedge clk); #1;
      @(negedge clk); check_bus({tag, ".err2"}, 1'b1, 1'b1, 32'h0);
      @(posedge clk); #1;
      @(negedge clk); check_bus({tag, ".idle"}, 1'b1, 1'b0, 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst     = 1'b1;
    h_sel   = 1'b0; h_addr = '0; h_trans = 2'b00; h_write = 1'b0; h_size = 3'b010;
    h_wdata = '0;
    z_sel   = 1'b0; z_addr = '0; z_trans = 2'b00; z_write = 1'b0; z_size = 3'b010;
    z_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bus("rst", 1'b1, 1'b0, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check_bus("idle", 1'b1, 1'b0, 32'h0);
      @(posedge clk); #1;
    end

    // BUSY transfer is not accepted
    h_sel = 1'b1; h_trans = 2'b01; h_addr = 32'h10;
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk); check_bus("busy", 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;

    xfer("wr10", 1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, 1'b0, 32'h0);
    xfer("rd10", 1'b0, 32'h10, 3'b010, 32'h0,         1'b0, 32'hDEAD_BEEF);

    xfer("rd1000", 1'b0, 32'h1000, 3'b010, 32'h0, 1'b1, 32'h0);
    xfer("rd6",    1'b0, 32'h6,    3'b010, 32'h0, 1'b1, 32'h0);
    xfer("rdbyte", 1'b0, 32'h0,    3'b000, 32'h0, 1'b1, 32'h0);

    xfer("wr4",    1'b1, 32'h4,    3'b010, 32'h0,         1'b0, 32'h0);
    xfer("wr1004", 1'b1, 32'h1004, 3'b010, 32'hFFFF_FFFF, 1'b1, 32'h0);
    xfer("rd4",    1'b0, 32'h4,    3'b010, 32'h0,         1'b0, 32'h0);
    xfer("rd10b",  1'b0, 32'h10,   3'b010, 32'h0,         1'b0, 32'hDEAD_BEEF);

    // Reset during the wait cycle of a write aborts it
    xfer("wr8", 1'b1, 32'h8, 3'b010, 32'h0, 1'b0, 32'h0);
    h_sel = 1'b1; h_trans = 2'b10; h_write = 1'b1; h_addr = 32'h8; h_size = 3'b010;
    @(posedge clk); #1;
    bus_idle();
    h_wdata = 32'hA5A5_A5A5;
    @(negedge clk); check_bus("abort.wait", 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1; check_bus("abort.rst", 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    xfer("rd8", 1'b0, 32'h8, 3'b010, 32'h0, 1'b0, 32'h0);

    // Zero-wait back-to-back write then read of the same word
    z_sel = 1'b1; z_trans = 2'b10; z_write = 1'b1; z_addr = 32'h20; z_size = 3'b010;
    @(posedge clk); #1;
    z_wdata = 32'h1234_5678;
    z_write = 1'b0;
    @(negedge clk);
    check("b2b.wr.ready", {31'd0, z_readyout}, 32'd1);
    check("b2b.wr.resp",  {31'd0, z_resp},     32'd0);
    check("b2b.wr.rdata", z_rdata, 32'h0);
    @(posedge clk); #1;
    z_sel = 1'b0; z_trans = 2'b00; z_wdata = 32'h0;
    @(negedge clk);
    check("b2b.rd.ready", {31'd0, z_readyout}, 32'd1);
    check("b2b.rd.resp",  {31'd0, z_resp},     32'd0);
    check("b2b.rd.rdata", z_rdata, 32'h1234_5678);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b.idle.rdata", z_rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
